// File: rtl/muldiv_issue.sv
// Pipeline-side initiator for the iterative multiply/divide core: resolves divide-by-zero,
// signed overflow and repeated operations locally, otherwise issues magnitudes and fixes signs.
module muldiv_issue #(
    parameter int unsigned DRAIN_CYCLES = 80
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        core_execute,
    output logic        core_div,
    output logic [31:0] core_opa,
    output logic [31:0] core_opb,
    input  logic        core_ready,
    input  logic [31:0] core_lo,
    input  logic [31:0] core_hi
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    typedef enum logic [2:0] {S_DRAIN, S_IDLE, S_ISSUE, S_WAIT, S_FIXUP, S_RESP} state_e;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic            a_signed;
        logic            b_signed;
        logic            div;
    } key_t;

    function automatic logic a_is_signed(input logic [2:0] f);
        return f[2] ? ~f[0] : (f[1:0] != 2'b11);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f);
        return f[2] ? ~f[0] : ~f[1];
    endfunction

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? (~x + XLEN'(1)) : x;
    endfunction

    // {hi, lo} holds {product high, product low} or {remainder, quotient}
    function automatic logic [XLEN-1:0] select_result(input logic [2:0] f, input logic [2*XLEN-1:0] r);
        if (f == 3'b000)  return r[XLEN-1:0];
        else if (!f[2])   return r[2*XLEN-1:XLEN];
        else if (!f[1])   return r[XLEN-1:0];
        else              return r[2*XLEN-1:XLEN];
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  drain_q, drain_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [2:0]        f3_q, f3_d;
    logic              cache_valid_q, cache_valid_d;
    key_t              cache_key_q, cache_key_d;
    logic [2*XLEN-1:0] cache_res_q, cache_res_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_data_q, resp_data_d;
    logic              core_execute_q, core_execute_d;
    logic              core_div_q, core_div_d;
    logic [XLEN-1:0]   core_opa_q, core_opa_d, core_opb_q, core_opb_d;

    // Request classification on the live inputs (used only in IDLE)
    key_t req_key;
    logic req_div0, req_ovf, req_hit;

    assign req_key  = '{a: rs1, b: rs2, a_signed: a_is_signed(funct3),
                        b_signed: b_is_signed(funct3), div: funct3[2]};
    assign req_div0 = funct3[2] && (rs2 == '0);
    assign req_ovf  = funct3[2] && !funct3[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    assign req_hit  = cache_valid_q && (cache_key_q == req_key);

    // Sign fix-up of the core's unsigned result for the latched op
    logic              fix_a_neg, fix_b_neg;
    logic [2*XLEN-1:0] fix_prod, fix_mul, fix_res;
    logic [XLEN-1:0]   fix_quot, fix_rem;
    key_t              fix_key;

    assign fix_a_neg = a_is_signed(f3_q) && a_q[XLEN-1];
    assign fix_b_neg = b_is_signed(f3_q) && b_q[XLEN-1];
    assign fix_prod  = {core_hi, core_lo};
    assign fix_mul   = (fix_a_neg ^ fix_b_neg) ? (~fix_prod + (2*XLEN)'(1)) : fix_prod;
    assign fix_quot  = (fix_a_neg ^ fix_b_neg) ? (~core_lo + XLEN'(1)) : core_lo;
    assign fix_rem   = fix_a_neg ? (~core_hi + XLEN'(1)) : core_hi;
    assign fix_res   = f3_q[2] ? {fix_rem, fix_quot} : fix_mul;
    assign fix_key   = '{a: a_q, b: b_q, a_signed: a_is_signed(f3_q),
                        b_signed: b_is_signed(f3_q), div: f3_q[2]};

    always_comb begin
        state_d        = state_q;
        drain_d        = drain_q;
        a_d            = a_q;
        b_d            = b_q;
        f3_d           = f3_q;
        cache_valid_d  = cache_valid_q;
        cache_key_d    = cache_key_q;
        cache_res_d    = cache_res_q;
        resp_valid_d   = 1'b0;
        resp_data_d    = '0;
        core_execute_d = 1'b0;
        core_div_d     = core_div_q;
        core_opa_d     = core_opa_q;
        core_opb_d     = core_opb_q;

        unique case (state_q)
            S_DRAIN: begin
                if (drain_q == '0) state_d = S_IDLE;
                else               drain_d = drain_q - CNT_W'(1);
            end
            S_IDLE: begin
                if (req_valid) begin
                    a_d  = rs1;
                    b_d  = rs2;
                    f3_d = funct3;
                    if (req_div0) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_data_d  = funct3[1] ? rs1 : {XLEN{1'b1}};
                    end else if (req_ovf) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_data_d  = funct3[1] ? '0 : 32'h8000_0000;
                    end else if (req_hit) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_data_d  = select_result(funct3, cache_res_q);
                    end else begin
                        state_d        = S_ISSUE;
                        core_execute_d = 1'b1;
                        core_div_d     = funct3[2];
                        core_opa_d     = magnitude(rs1, a_is_signed(funct3));
                        core_opb_d     = magnitude(rs2, b_is_signed(funct3));
                    end
                end
            end
            // ready is not looked at here: it may still be high from the previous op
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (core_ready) state_d = S_FIXUP;
            end
            S_FIXUP: begin
                state_d       = S_RESP;
                cache_valid_d = 1'b1;
                cache_key_d   = fix_key;
                cache_res_d   = fix_res;
                resp_valid_d  = 1'b1;
                resp_data_d   = select_result(f3_q, fix_res);
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_DRAIN;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= S_DRAIN;
            drain_q        <= CNT_W'(DRAIN_CYCLES);
            cache_valid_q  <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            core_execute_q <= 1'b0;
            core_div_q     <= 1'b0;
            core_opa_q     <= '0;
            core_opb_q     <= '0;
        end else begin
            state_q        <= state_d;
            drain_q        <= drain_d;
            cache_valid_q  <= cache_valid_d;
            resp_valid_q   <= resp_valid_d;
            resp_data_q    <= resp_data_d;
            core_execute_q <= core_execute_d;
            core_div_q     <= core_div_d;
            core_opa_q     <= core_opa_d;
            core_opb_q     <= core_opb_d;
        end
    end

    // Datapath latches need no reset; the cache is gated by its valid bit
    always_ff @(posedge Clk) begin
        a_q         <= a_d;
        b_q         <= b_d;
        f3_q        <= f3_d;
        cache_key_q <= cache_key_d;
        cache_res_q <= cache_res_d;
    end

    assign stall        = req_valid & ~resp_valid_q;
    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign core_execute = core_execute_q;
    assign core_div     = core_div_q;
    assign core_opa     = core_opa_q;
    assign core_opb     = core_opb_q;

endmodule
